// File: rtl/cpi_con_pkg.sv
// Shared types for the CPI global-channel connection controller.
package cpi_con_pkg;

  typedef enum logic [2:0] {
    ST_DISCON        = 3'd0,
    ST_CONNECTING    = 3'd1,
    ST_CONNECTED     = 3'd2,
    ST_DISCONNECTING = 3'd3,
    ST_NACK_WAIT     = 3'd4,
    ST_ERROR         = 3'd5
  } cpi_con_state_e;

  localparam int NACK_CNT_W = 8;

endpackage

// File: rtl/cpi_con_if.sv
// Agent/fabric connect handshake of the CPI global channel.
interface cpi_con_if;
  logic txcon_req;
  logic rxcon_ack;
  logic rxdiscon_nack;
  logic rx_empty;

  modport master (output txcon_req, input rxcon_ack, input rxdiscon_nack, input rx_empty);
  modport slave  (input txcon_req, output rxcon_ack, output rxdiscon_nack, output rx_empty);
endinterface

// File: rtl/cpi_con_timer.sv
// Clearable saturating up-counter with a terminal-compare flag.
module cpi_con_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] cmp,
  output logic         hit
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign hit = (cnt == cmp);

endmodule

// File: rtl/cpi_con_ctrl.sv
// Agent-side CPI connect/disconnect sequencer with timeouts and sticky fatal/viral.
module cpi_con_ctrl
  import cpi_con_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int RETRY_GAP      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  link_en,
  input  logic                  tx_idle,
  input  logic                  fatal_in,
  input  logic                  viral_in,
  cpi_con_if.master             cpi,
  output logic                  fatal,
  output logic                  viral,
  output logic                  connected,
  output logic [2:0]            state,
  output logic [NACK_CNT_W-1:0] nack_cnt
);

  localparam int TMR_MAX = (TIMEOUT_CYCLES > RETRY_GAP) ? TIMEOUT_CYCLES : RETRY_GAP;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(RETRY_GAP - 1);

  function automatic logic [NACK_CNT_W-1:0] sat_inc(input logic [NACK_CNT_W-1:0] v);
    return (v == {NACK_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  cpi_con_state_e        state_q, state_d;
  logic [TMR_W-1:0]      tmr_cmp;
  logic                  tmr_hit;
  logic                  nack_inc;
  logic                  txcon_d, conn_d, fatal_d, viral_d;
  logic [NACK_CNT_W-1:0] nack_d;
  logic                  txcon_q;

  // One timer serves both phase timeouts and the retry gap.
  assign tmr_cmp = (state_q == ST_NACK_WAIT) ? GAP_LAST : TO_LAST;

  cpi_con_timer #(.W(TMR_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_d != state_q),
    .en    (1'b1),
    .cmp   (tmr_cmp),
    .hit   (tmr_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_DISCON;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (fatal_in && (state_q != ST_ERROR)) begin
      state_d = ST_ERROR;
    end else begin
      unique case (state_q)
        ST_DISCON:
          if (link_en && !cpi.rxcon_ack) state_d = ST_CONNECTING;
        ST_CONNECTING:
          if (cpi.rxcon_ack)  state_d = ST_CONNECTED;
          else if (tmr_hit)   state_d = ST_ERROR;
        ST_CONNECTED:
          if (!cpi.rxcon_ack)           state_d = ST_ERROR;
          else if (!link_en && tx_idle) state_d = ST_DISCONNECTING;
        ST_DISCONNECTING:
          // NACK outranks a concurrent ack drop / empty indication.
          if (cpi.rxdiscon_nack)                     state_d = ST_NACK_WAIT;
          else if (!cpi.rxcon_ack && cpi.rx_empty)   state_d = ST_DISCON;
          else if (tmr_hit)                          state_d = ST_ERROR;
        ST_NACK_WAIT:
          if (tmr_hit) state_d = ST_CONNECTED;
        default: state_d = ST_ERROR;
      endcase
    end
  end

  assign nack_inc = (state_q == ST_DISCONNECTING) && (state_d == ST_NACK_WAIT);

  always_comb begin
    txcon_d = (state_d == ST_CONNECTING) || (state_d == ST_CONNECTED);
    conn_d  = (state_d == ST_CONNECTED);
    fatal_d = fatal | (state_d == ST_ERROR);
    viral_d = viral | viral_in | (state_d == ST_ERROR);
    nack_d  = nack_inc ? sat_inc(nack_cnt) : nack_cnt;
  end

  // Output register stage: every output is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txcon_q   <= 1'b0;
      connected <= 1'b0;
      fatal     <= 1'b0;
      viral     <= 1'b0;
      nack_cnt  <= '0;
    end else begin
      txcon_q   <= txcon_d;
      connected <= conn_d;
      fatal     <= fatal_d;
      viral     <= viral_d;
      nack_cnt  <= nack_d;
    end
  end

  assign cpi.txcon_req = txcon_q;
  assign state         = state_q;

endmodule
